// File: rtl/csa_accumulator.sv
// csa_accumulator: multi-beat carry-save accumulator for the MAC datapath.
// Each accepted beat folds LANES operands into a redundant (sum, carry) pair
// through a chain of 3:2 compressor rows; the final beat of an accumulation
// registers the pair, its carry-propagated sum and the beat count on a
// valid/ready output port.
module csa_accumulator #(
    parameter int XLEN  = 49,   // operand / accumulator / result width
    parameter int LANES = 2,    // operands per beat, 1..4
    parameter int CNT_W = 8     // saturating beat counter width
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_last_i,
    input  logic [LANES*XLEN-1:0] operands_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       out_sum_o,
    output logic [XLEN-1:0]       out_cy_o,
    output logic [XLEN-1:0]       out_result_o,
    output logic [CNT_W-1:0]      out_count_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [XLEN-1:0]  acc_s_q, acc_s_d;
    logic [XLEN-1:0]  acc_c_q, acc_c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_sum_q, out_sum_d;
    logic [XLEN-1:0]  out_cy_q, out_cy_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             in_accept;
    logic             out_accept;
    logic [CNT_W-1:0] cnt_inc;

    // Compressor chain: row gi+1 is row gi's (sum, carry) merged with operand gi.
    logic [LANES:0][XLEN-1:0] row_s;
    logic [LANES:0][XLEN-1:0] row_c;
    logic [XLEN-1:0]          final_sum;

    assign row_s[0] = acc_s_q;
    assign row_c[0] = acc_c_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_row
            logic [XLEN-1:0] op;
            logic [XLEN-1:0] maj;
            assign op  = operands_i[gi*XLEN +: XLEN];
            assign maj = (row_s[gi] & row_c[gi]) | (row_s[gi] & op) | (row_c[gi] & op);
            assign row_s[gi+1] = row_s[gi] ^ row_c[gi] ^ op;
            // Weight-align the carry; the top carry bit falls off (mod 2^XLEN).
            assign row_c[gi+1] = {maj[XLEN-2:0], 1'b0};
        end
    endgenerate

    assign final_sum = row_s[LANES] + row_c[LANES];

    // A waiting result blocks input unless it is being consumed this cycle.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign in_accept  = in_valid_i && in_ready_o;
    assign out_accept = out_valid_q && out_ready_i;
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state: absorb non-last beats, retire the accumulation on the last beat.
    always_comb begin
        state_d      = state_q;
        acc_s_d      = acc_s_q;
        acc_c_d      = acc_c_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_cy_d     = out_cy_q;
        out_result_d = out_result_q;
        out_count_d  = out_count_q;

        if (out_accept) begin
            out_valid_d = 1'b0;
        end

        if (in_accept) begin
            if (in_last_i) begin
                out_valid_d  = 1'b1;
                out_sum_d    = row_s[LANES];
                out_cy_d     = row_c[LANES];
                out_result_d = final_sum;
                out_count_d  = cnt_inc;
                acc_s_d      = '0;
                acc_c_d      = '0;
                cnt_d        = '0;
                state_d      = IDLE;
            end else begin
                acc_s_d = row_s[LANES];
                acc_c_d = row_c[LANES];
                cnt_d   = cnt_inc;
                state_d = ACCUM;
            end
        end
    end

    // State registers with synchronous reset taking priority over any handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            acc_s_q      <= '0;
            acc_c_q      <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_cy_q     <= '0;
            out_result_q <= '0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_s_q      <= acc_s_d;
            acc_c_q      <= acc_c_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_cy_q     <= out_cy_d;
            out_result_q <= out_result_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_sum_o    = out_sum_q;
    assign out_cy_o     = out_cy_q;
    assign out_result_o = out_result_q;
    assign out_count_o  = out_count_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Testbench for csa_accumulator: directed beats, expected results queued at
// issue time and checked by an independent monitor on each output accept.
module tb_csa_accumulator;

    localparam int XLEN  = 49;
    localparam int LANES = 2;
    localparam int CNT_W = 2;   // small counter so saturation is reachable

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  in_last_i;
    logic [LANES*XLEN-1:0] operands_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [XLEN-1:0]       out_sum_o;
    logic [XLEN-1:0]       out_cy_o;
    logic [XLEN-1:0]       out_result_o;
    logic [CNT_W-1:0]      out_count_o;

    typedef struct {
        logic [XLEN-1:0]  result;
        logic [CNT_W-1:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    csa_accumulator #(.XLEN(XLEN), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_last_i    (in_last_i),
        .operands_i   (operands_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_sum_o    (out_sum_o),
        .out_cy_o     (out_cy_o),
        .out_result_o (out_result_o),
        .out_count_o  (out_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push(input logic [XLEN-1:0] r, input logic [CNT_W-1:0] c);
        exp_t e;
        e.result = r;
        e.count  = c;
        exp_q.push_back(e);
    endtask

    // Drive one beat (called just after a rising edge) and hold it until accepted.
    task automatic beat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic last);
        int n = 0;
        in_valid_i = 1'b1;
        in_last_i  = last;
        operands_i = {b, a};
        @(negedge clk);
        while (!in_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_o) check("beat_accept_timeout", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    // Monitor: every output accept pops one expectation and checks it.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            logic [XLEN-1:0] redundant_sum;
            redundant_sum = out_sum_o + out_cy_o;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(out_result_o), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'(out_result_o), 64'(e.result));
                check("count", 64'(out_count_o), 64'(e.count));
                check("sum_plus_cy", 64'(redundant_sum), 64'(e.result));
                check("cy_bit0", 64'(out_cy_o[0]), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        operands_i  = '0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_result", 64'(out_result_o), 64'd0);
        check("rst_count", 64'(out_count_o), 64'd0);
        check("rst_sum", 64'(out_sum_o), 64'd0);
        check("rst_cy", 64'(out_cy_o), 64'd0);
        @(posedge clk);
        #1;

        // Single beat {5,7}
        push(49'd12, 2'd1);
        beat(49'd5, 49'd7, 1'b1);
        @(negedge clk);
        check("single_valid", 64'(out_valid_o), 64'd1);
        @(negedge clk);
        check("single_valid_drop", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1;

        // Three beats summing to 40
        push(49'd40, 2'd3);
        beat(49'd1, 49'd2, 1'b0);
        beat(49'd3, 49'd4, 1'b0);
        beat(49'd10, 49'd20, 1'b1);

        // Wrap cases, issued back to back
        push(49'd0, 2'd1);
        beat({XLEN{1'b1}}, 49'd1, 1'b1);
        push(49'd0, 2'd1);
        beat(49'h1_0000_0000_0000, 49'h1_0000_0000_0000, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;

        // Backpressure: hold a result, then a pending last beat must stall
        out_ready_i = 1'b0;
        push(49'd100, 2'd1);
        beat(49'd60, 49'd40, 1'b1);
        in_valid_i = 1'b1;
        in_last_i  = 1'b1;
        operands_i = {49'd4, 49'd3};
        repeat (3) @(negedge clk);
        check("bp_in_ready", 64'(in_ready_o), 64'd0);
        check("bp_out_valid", 64'(out_valid_o), 64'd1);
        check("bp_result_held", 64'(out_result_o), 64'd100);
        check("bp_count_held", 64'(out_count_o), 64'd1);
        @(posedge clk);
        #1;
        push(49'd7, 2'd1);
        out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        @(negedge clk);
        check("bp_valid_stays", 64'(out_valid_o), 64'd1);
        @(posedge clk);
        #1;

        // Reset mid-accumulation discards partial state
        beat(49'd9, 49'd9, 1'b0);
        beat(49'd9, 49'd9, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        push(49'd2, 2'd1);
        beat(49'd1, 49'd1, 1'b1);

        // Counter saturation: five beats with a 2-bit counter
        push(49'd5, 2'd3);
        for (int i = 0; i < 5; i++) begin
            beat(49'd1, 49'd0, (i == 4));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
